// File: rtl/ten_gig_tx_arbiter_pkg.sv
// Shared types and constants for the 10G transmit arbiter slice.
package ten_gig_tx_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_USER_W = 32;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_FWD0,
        ST_FWD1,
        ST_DRAIN0,
        ST_DRAIN1
    } arb_state_t;

endpackage

// File: rtl/ten_gig_rr_sel.sv
// Two-input round-robin selector: a lone requester wins, otherwise the
// source not served last wins.
module ten_gig_rr_sel (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_served ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/ten_gig_tx_arbiter.sv
// Packet-granular two-source arbiter feeding the 10G MAC transmit stream,
// with drain-on-link-down and per-source/drop packet counters.
module ten_gig_tx_arbiter
    import ten_gig_tx_arbiter_pkg::*;
#(
    parameter int P_DATA_W       = DEF_DATA_W,
    parameter int P_USER_W       = DEF_USER_W,
    parameter int P_DROP_ON_DOWN = 1
) (
    input  logic                  i_xgmii_clk,
    input  logic                  i_xgmii_rst_n,
    input  logic                  i_block_sync,
    input  logic                  i_pcs_rx_link,
    input  logic [P_DATA_W-1:0]   s0_axis_tdata,
    input  logic [P_USER_W-1:0]   s0_axis_tuser,
    input  logic [P_DATA_W/8-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic [P_DATA_W-1:0]   s1_axis_tdata,
    input  logic [P_USER_W-1:0]   s1_axis_tuser,
    input  logic [P_DATA_W/8-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    output logic [P_DATA_W-1:0]   m_axis_tdata,
    output logic [P_USER_W-1:0]   m_axis_tuser,
    output logic [P_DATA_W/8-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CNT_W-1:0]      o_pkt_cnt0,
    output logic [CNT_W-1:0]      o_pkt_cnt1,
    output logic [CNT_W-1:0]      o_drop_cnt,
    output logic [1:0]            o_grant
);

    arb_state_t       state, state_nxt;
    logic             last_served, last_served_nxt;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt0_nxt;
    logic [CNT_W-1:0] pkt_cnt1, pkt_cnt1_nxt;
    logic [CNT_W-1:0] drop_cnt, drop_cnt_nxt;
    logic [1:0]       sel;
    logic             link_up;
    logic             end0, end1;

    assign link_up = i_block_sync & i_pcs_rx_link;
    assign end0    = s0_axis_tvalid & s0_axis_tready & s0_axis_tlast;
    assign end1    = s1_axis_tvalid & s1_axis_tready & s1_axis_tlast;

    ten_gig_rr_sel u_rr_sel (
        .req         ({s1_axis_tvalid, s0_axis_tvalid}),
        .last_served (last_served),
        .gnt         (sel)
    );

    // Counters and pointer are rewritten every cycle from their next values.
    always_ff @(posedge i_xgmii_clk or negedge i_xgmii_rst_n) begin
        if (!i_xgmii_rst_n) begin
            state       <= ST_IDLE;
            last_served <= 1'b1;
            pkt_cnt0    <= '0;
            pkt_cnt1    <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
            pkt_cnt0    <= pkt_cnt0_nxt;
            pkt_cnt1    <= pkt_cnt1_nxt;
            drop_cnt    <= drop_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (sel == 2'b00)             state_nxt = ST_IDLE;
                else if (link_up)             state_nxt = sel[0] ? ST_FWD0 : ST_FWD1;
                else if (P_DROP_ON_DOWN != 0) state_nxt = sel[0] ? ST_DRAIN0 : ST_DRAIN1;
                else                          state_nxt = ST_IDLE;
            end
            ST_FWD0, ST_DRAIN0: if (end0) state_nxt = ST_IDLE;
            ST_FWD1, ST_DRAIN1: if (end1) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tuser   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        m_axis_tvalid  = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        o_grant        = 2'b00;
        case (state)
            ST_FWD0: begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tuser   = s0_axis_tuser;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tvalid  = s0_axis_tvalid;
                s0_axis_tready = m_axis_tready;
                o_grant        = 2'b01;
            end
            ST_FWD1: begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tuser   = s1_axis_tuser;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tlast   = s1_axis_tlast;
                m_axis_tvalid  = s1_axis_tvalid;
                s1_axis_tready = m_axis_tready;
                o_grant        = 2'b10;
            end
            ST_DRAIN0: begin
                s0_axis_tready = 1'b1;
                o_grant        = 2'b01;
            end
            ST_DRAIN1: begin
                s1_axis_tready = 1'b1;
                o_grant        = 2'b10;
            end
            default: ;
        endcase
    end

    // tready is only ever high for the owning source, so end0/end1 imply ownership.
    always_comb begin
        last_served_nxt = last_served;
        pkt_cnt0_nxt    = pkt_cnt0;
        pkt_cnt1_nxt    = pkt_cnt1;
        drop_cnt_nxt    = drop_cnt;
        if (end0) last_served_nxt = 1'b0;
        if (end1) last_served_nxt = 1'b1;
        if (state == ST_FWD0 && end0) pkt_cnt0_nxt = pkt_cnt0 + CNT_W'(1);
        if (state == ST_FWD1 && end1) pkt_cnt1_nxt = pkt_cnt1 + CNT_W'(1);
        if ((state == ST_DRAIN0 && end0) || (state == ST_DRAIN1 && end1))
            drop_cnt_nxt = drop_cnt + CNT_W'(1);
    end

    assign o_pkt_cnt0 = pkt_cnt0;
    assign o_pkt_cnt1 = pkt_cnt1;
    assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_ten_gig_tx_arbiter.sv
// Directed, table-driven bench for ten_gig_tx_arbiter; one row per clock cycle.
module tb_ten_gig_tx_arbiter;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
    localparam logic [1:0] N0 = 2'b00;
    localparam logic [1:0] S0 = 2'b01;
    localparam logic [1:0] S1 = 2'b10;
    localparam logic [7:0] Z  = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bsync, plink;
    logic [63:0] s0_tdata, s1_tdata, m_tdata;
    logic [31:0] s0_tuser, s1_tuser, m_tuser;
    logic [7:0]  s0_tkeep, s1_tkeep, m_tkeep;
    logic        s0_tlast, s0_tvalid, s0_tready;
    logic        s1_tlast, s1_tvalid, s1_tready;
    logic        m_tlast, m_tvalid, m_tready;
    logic [15:0] cnt0, cnt1, dcnt;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ten_gig_tx_arbiter #(
        .P_DATA_W       (64),
        .P_USER_W       (32),
        .P_DROP_ON_DOWN (1)
    ) dut (
        .i_xgmii_clk    (clk),
        .i_xgmii_rst_n  (rst_n),
        .i_block_sync   (bsync),
        .i_pcs_rx_link  (plink),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tuser  (s0_tuser),
        .s0_axis_tkeep  (s0_tkeep),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tuser  (s1_tuser),
        .s1_axis_tkeep  (s1_tkeep),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tuser   (m_tuser),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tlast   (m_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .o_pkt_cnt0     (cnt0),
        .o_pkt_cnt1     (cnt1),
        .o_drop_cnt     (dcnt),
        .o_grant        (grant)
    );

    // src uses the grant encoding: which source m_axis must mirror (N0 = all zero).
    typedef struct packed {
        logic        bs, pl, v0, l0;
        logic [7:0]  d0;
        logic        v1, l1;
        logic [7:0]  d1;
        logic        rdy;
        logic [1:0]  src;
        logic        mv, r0, r1;
        logic [1:0]  g;
        logic [15:0] c0, c1, cd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bsync     = v.bs;
        plink     = v.pl;
        s0_tvalid = v.v0;
        s0_tlast  = v.l0;
        s0_tdata  = {8{v.d0}};
        s0_tuser  = {4{v.d0}};
        s0_tkeep  = 8'hFF;
        s1_tvalid = v.v1;
        s1_tlast  = v.l1;
        s1_tdata  = {8{v.d1}};
        s1_tuser  = {4{v.d1}};
        s1_tkeep  = 8'h0F;
        m_tready  = v.rdy;
    endtask

    task automatic compare(input int i, input vec_t v);
        logic [104:0] em;
        case (v.src)
            S0:      em = {{8{v.d0}}, {4{v.d0}}, 8'hFF, v.l0};
            S1:      em = {{8{v.d1}}, {4{v.d1}}, 8'h0F, v.l1};
            default: em = '0;
        endcase
        check($sformatf("row%0d m_bus", i), 128'({m_tdata, m_tuser, m_tkeep, m_tlast}), 128'(em));
        check($sformatf("row%0d m_tvalid", i), 128'(m_tvalid), 128'(v.mv));
        check($sformatf("row%0d s0_tready", i), 128'(s0_tready), 128'(v.r0));
        check($sformatf("row%0d s1_tready", i), 128'(s1_tready), 128'(v.r1));
        check($sformatf("row%0d grant", i), 128'(grant), 128'(v.g));
        check($sformatf("row%0d counters", i), 128'({cnt0, cnt1, dcnt}), 128'({v.c0, v.c1, v.cd}));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " grant"}, 128'(grant), 128'(2'b00));
        check({tag, " m_tvalid"}, 128'(m_tvalid), 128'(1'b0));
        check({tag, " treadys"}, 128'({s0_tready, s1_tready}), 128'(2'b00));
        check({tag, " m_bus"}, 128'({m_tdata, m_tuser, m_tkeep, m_tlast}), 128'(0));
        check({tag, " counters"}, 128'({cnt0, cnt1, dcnt}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        // Simultaneous requests right after reset: s0, s1, s0, s1 with 1-beat packets.
        vecs.push_back(vec_t'{H,H,H,H,8'hB0,H,H,8'hB1,H, N0,L,L,L,N0, 16'd0,16'd0,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB0,H,H,8'hB1,H, N0,L,L,L,N0, 16'd0,16'd0,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB0,H,H,8'hB1,H, S0,H,H,L,S0, 16'd0,16'd0,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB2,H,H,8'hB3,H, N0,L,L,L,N0, 16'd1,16'd0,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB2,H,H,8'hB3,H, N0,L,L,L,N0, 16'd1,16'd0,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB2,H,H,8'hB3,H, S1,H,L,H,S1, 16'd1,16'd0,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB4,H,H,8'hB5,H, N0,L,L,L,N0, 16'd1,16'd1,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB4,H,H,8'hB5,H, N0,L,L,L,N0, 16'd1,16'd1,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB4,H,H,8'hB5,H, S0,H,H,L,S0, 16'd1,16'd1,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB6,H,H,8'hB7,H, N0,L,L,L,N0, 16'd2,16'd1,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB6,H,H,8'hB7,H, N0,L,L,L,N0, 16'd2,16'd1,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hB6,H,H,8'hB7,H, S1,H,L,H,S1, 16'd2,16'd1,16'd0});
        vecs.push_back(vec_t'{H,H,L,L,Z,L,L,Z,H,           N0,L,L,L,N0, 16'd2,16'd2,16'd0});
        // s0 three-beat packet, link up, sink always ready.
        vecs.push_back(vec_t'{H,H,H,L,8'hA1,L,L,Z,H, N0,L,L,L,N0, 16'd2,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'hA1,L,L,Z,H, N0,L,L,L,N0, 16'd2,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'hA1,L,L,Z,H, S0,H,H,L,S0, 16'd2,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'hA2,L,L,Z,H, S0,H,H,L,S0, 16'd2,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,H,8'hA3,L,L,Z,H, S0,H,H,L,S0, 16'd2,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,L,L,Z,L,L,Z,H,     N0,L,L,L,N0, 16'd3,16'd2,16'd0});
        // s1 four-beat packet with sink ready toggling; s0 waits with valid high.
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,L,8'hC1,H, N0,L,L,L,N0, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,L,8'hC1,H, N0,L,L,L,N0, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,L,8'hC1,H, S1,H,L,H,S1, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,L,8'hC2,L, S1,H,L,L,S1, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,L,8'hC2,H, S1,H,L,H,S1, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,L,8'hC3,L, S1,H,L,L,S1, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,L,8'hC3,H, S1,H,L,H,S1, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,H,8'hC4,L, S1,H,L,L,S1, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,H,L,8'h5A,H,H,8'hC4,H, S1,H,L,H,S1, 16'd3,16'd2,16'd0});
        vecs.push_back(vec_t'{H,H,L,L,Z,L,L,Z,H,         N0,L,L,L,N0, 16'd3,16'd3,16'd0});
        // Block sync lost: s0 two-beat packet is drained, sink not ready.
        vecs.push_back(vec_t'{L,H,H,L,8'hD1,L,L,Z,L, N0,L,L,L,N0, 16'd3,16'd3,16'd0});
        vecs.push_back(vec_t'{L,H,H,L,8'hD1,L,L,Z,L, N0,L,L,L,N0, 16'd3,16'd3,16'd0});
        vecs.push_back(vec_t'{L,H,H,L,8'hD1,L,L,Z,L, N0,L,H,L,S0, 16'd3,16'd3,16'd0});
        vecs.push_back(vec_t'{L,H,H,H,8'hD2,L,L,Z,L, N0,L,H,L,S0, 16'd3,16'd3,16'd0});
        vecs.push_back(vec_t'{H,H,L,L,Z,L,L,Z,L,     N0,L,L,L,N0, 16'd3,16'd3,16'd1});
        // Link drops at beat 2 of a five-beat packet; the following packet is drained.
        vecs.push_back(vec_t'{H,H,H,L,8'hE1,L,L,Z,H, N0,L,L,L,N0, 16'd3,16'd3,16'd1});
        vecs.push_back(vec_t'{H,H,H,L,8'hE1,L,L,Z,H, N0,L,L,L,N0, 16'd3,16'd3,16'd1});
        vecs.push_back(vec_t'{H,H,H,L,8'hE1,L,L,Z,H, S0,H,H,L,S0, 16'd3,16'd3,16'd1});
        vecs.push_back(vec_t'{H,L,H,L,8'hE2,L,L,Z,H, S0,H,H,L,S0, 16'd3,16'd3,16'd1});
        vecs.push_back(vec_t'{H,L,H,L,8'hE3,L,L,Z,H, S0,H,H,L,S0, 16'd3,16'd3,16'd1});
        vecs.push_back(vec_t'{H,L,H,L,8'hE4,L,L,Z,H, S0,H,H,L,S0, 16'd3,16'd3,16'd1});
        vecs.push_back(vec_t'{H,L,H,H,8'hE5,L,L,Z,H, S0,H,H,L,S0, 16'd3,16'd3,16'd1});
        vecs.push_back(vec_t'{H,L,H,H,8'hF1,L,L,Z,H, N0,L,L,L,N0, 16'd4,16'd3,16'd1});
        vecs.push_back(vec_t'{H,L,H,H,8'hF1,L,L,Z,H, N0,L,L,L,N0, 16'd4,16'd3,16'd1});
        vecs.push_back(vec_t'{H,L,H,H,8'hF1,L,L,Z,H, N0,L,H,L,S0, 16'd4,16'd3,16'd1});
        vecs.push_back(vec_t'{H,H,L,L,Z,L,L,Z,H,     N0,L,L,L,N0, 16'd4,16'd3,16'd2});

        rst_n = 1'b0;
        drive(vec_t'{H,H,L,L,Z,L,L,Z,L, N0,L,L,L,N0, 16'd0,16'd0,16'd0});
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            compare(i, vecs[i]);
        end

        // Preset the s0 counter to its top value, then forward one more packet.
        @(negedge clk);
        force dut.pkt_cnt0 = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.pkt_cnt0;
        check("wrap preset", 128'(cnt0), 128'(16'hFFFF));
        @(posedge clk);
        #1;
        s0_tvalid = 1'b1;
        s0_tlast  = 1'b1;
        s0_tdata  = {8{8'hEE}};
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (m_tvalid && m_tready && m_tlast) seen = 1'b1;
        end
        check("wrap beat seen", 128'(seen), 128'(1'b1));
        @(posedge clk);
        #1;
        s0_tvalid = 1'b0;
        check("wrap cnt0", 128'(cnt0), 128'(16'h0000));
        check("wrap cnt1", 128'(cnt1), 128'(16'd3));

        // Reset pulse in the middle of an s1 packet, away from the clock edge.
        @(posedge clk);
        #1;
        s1_tvalid = 1'b1;
        s1_tlast  = 1'b0;
        s1_tdata  = {8{8'h77}};
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (grant == 2'b10 && m_tvalid) seen = 1'b1;
        end
        check("midpkt fwd1 seen", 128'(seen), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midpkt reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset grant", 128'(grant), 128'(2'b00));
        check("post-reset m_tvalid", 128'(m_tvalid), 128'(1'b0));
        check("post-reset s1_tready", 128'(s1_tready), 128'(1'b0));
        @(posedge clk);
        #1;
        s1_tvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ten_gig_tx_arbiter.md
TEN_GIG_TX_ARBITER -- requirements
Module: ten_gig_tx_arbiter

Interface
REQ-001 SHALL have parameter P_DATA_W, default 64, the AXI-stream data width.
REQ-002 SHALL have parameter P_USER_W, default 32, the tuser width carried to the MAC (frame length/type).
REQ-003 SHALL have parameter P_DROP_ON_DOWN, default 1; 1 means source packets are drained while the link is down.
REQ-004 SHALL have port i_xgmii_clk, input, 1, the single clock (XGMII 156.25 MHz domain).
REQ-005 SHALL have port i_xgmii_rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have ports i_block_sync and i_pcs_rx_link, input, 1 each; link_up = i_block_sync AND i_pcs_rx_link.
REQ-007 SHALL have ports s0_axis_tdata/tuser/tkeep/tlast/tvalid, input (P_DATA_W/P_USER_W/8/1/1), and s0_axis_tready, output, 1: requester 0.
REQ-008 SHALL have the identical port set s1_axis_*: requester 1.
REQ-009 SHALL have ports m_axis_tdata/tuser/tkeep/tlast/tvalid, output, and m_axis_tready, input: toward the MAC transmit stream.
REQ-010 SHALL have ports o_pkt_cnt0 and o_pkt_cnt1, output, 16 each: forwarded-packet counters.
REQ-011 SHALL have port o_drop_cnt, output, 16: count of drained packets.
REQ-012 SHALL have port o_grant, output, 2: one-hot current owner; 00 when no source is granted.

Function
REQ-013 SHALL implement FSM states IDLE, ARB, FWD0, FWD1, DRAIN0, DRAIN1.
REQ-014 IDLE SHALL go to ARB when any sN_tvalid=1.
REQ-015 ARB SHALL last exactly one cycle and select a source by round-robin.
REQ-016 Round-robin rule: the source not served last wins on simultaneous requests; a single requester wins alone.
REQ-017 From ARB, a selected source SHALL go to FWDn if link_up=1.
REQ-018 From ARB, a selected source SHALL go to DRAINn if link_up=0 and P_DROP_ON_DOWN=1.
REQ-019 From ARB, the FSM SHALL return to IDLE if link_up=0 and P_DROP_ON_DOWN=0.
REQ-020 In FWDn, m_axis_t* SHALL equal sN_axis_t*, with m_axis_tvalid gated by the grant.
REQ-021 In FWDn, sN_axis_tready SHALL equal m_axis_tready; the non-granted tready SHALL be 0.
REQ-022 In FWDn, there SHALL be zero-cycle combinational pass-through; no beat is buffered, duplicated or dropped.
REQ-023 Grant SHALL be packet-granular: the FSM leaves FWDn only on a beat with tvalid&tready&tlast, then goes to IDLE.
REQ-024 The last-served pointer SHALL be updated on the tlast beat.
REQ-025 Link loss during FWDn SHALL NOT truncate the packet; it completes, and the link is re-evaluated at the next ARB.
REQ-026 In DRAINn, sN_axis_tready=1 and m_axis_tvalid=0.
REQ-027 DRAINn SHALL exit to IDLE on the tlast beat; o_drop_cnt +1 at that beat.
REQ-028 o_pkt_cntN SHALL increment by 1 on each forwarded tlast beat.
REQ-029 All counters SHALL wrap 0xFFFF -> 0x0000.
REQ-030 Best-case per-packet overhead SHALL be 2 idle cycles (IDLE, ARB) between packets.
REQ-031 In IDLE/ARB, all tready=0 and m_axis_tvalid=0; m_axis_tdata/tuser/tkeep/tlast SHALL be 0 when not in FWDn.

Reset
REQ-032 Asserting i_xgmii_rst_n low SHALL asynchronously force: state IDLE, o_grant=00, last-served=1 (so source 0 wins first), counters=0, all tready=0, m_axis_tvalid=0.
REQ-033 Reset mid-packet SHALL abandon the packet; no resumption after reset release.
REQ-034 Deassertion SHALL be synchronised externally; the block samples its first cycle on the first clock edge after release.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, P_DATA_W/P_USER_W defaults and the counter width constant (16).
REQ-036 One sub-module SHALL exist: ten_gig_rr_sel (2-input round-robin selector: request vector, last-served -> one-hot grant).
REQ-037 The remainder (FSM, muxes, counters) SHALL be a single module, target 150-300 lines.

Verification
REQ-038 Link up, s0 sends a 3-beat packet with m_axis_tready=1 -> beats appear on m_axis in the same cycles; o_pkt_cnt0=1; o_grant=01 during the packet.
REQ-039 Both sources assert valid at once after reset -> s0 served first, then s1; a repeat gives s0 then s1 again; counts 2/2.
REQ-040 m_axis_tready toggles 1010 during s1's 4-beat packet -> exactly 4 handshakes, data order preserved, s0_axis_tready=0 throughout.
REQ-041 Link down (i_block_sync=0) with P_DROP_ON_DOWN=1, s0 sends a 2-beat packet -> m_axis_tvalid stays 0; o_drop_cnt=1.
REQ-042 Link drops at beat 2 of a 5-beat FWD0 packet -> all 5 beats forwarded; the next packet is drained.
REQ-043 o_pkt_cnt0 preset by 65535 packets plus one more -> 0x0000; i_xgmii_rst_n pulsed low mid-packet -> all outputs at reset values immediately.
